// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial input and received-word outputs of the UART receiver
interface uart_rx_frame_if #(
    parameter int p_DATA_WIDTH = 8
) ();
    logic                    rx;
    logic [p_DATA_WIDTH-1:0] data;
    logic                    valid;
    logic                    frame_err;
    logic                    parity_err;
    logic                    busy;

    modport master (output rx, input data, valid, frame_err, parity_err, busy);
    modport slave  (input rx, output data, valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with 3-tap majority vote, false-start
// rejection, framing/break detection; parity checking enabled by UART_RX_PARITY_EN
module uart_rx_frame #(
    parameter int p_DATA_WIDTH   = 8,
    parameter int p_CLKS_PER_BIT = 16,
    parameter int p_STOP_BITS    = 1,
    parameter int p_PARITY_ODD   = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    uart_rx_frame_if.slave bus
);
    localparam int MID = p_CLKS_PER_BIT / 2;
    localparam int CW  = $clog2(p_CLKS_PER_BIT);
    localparam int BW  = $clog2(p_DATA_WIDTH);
    localparam logic [CW-1:0] VOTE_AT   = CW'(MID + 1);
    localparam logic [CW-1:0] BIT_END   = CW'(p_CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(p_DATA_WIDTH - 1);
    localparam logic          LAST_STOP = 1'(p_STOP_BITS - 1);
    localparam logic          ODD       = 1'(p_PARITY_ODD);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    state_t                  state;
    logic                    rx_m, rx_s;
    logic [1:0]              hist;
    logic [CW-1:0]           cnt;
    logic [BW-1:0]           bit_idx;
    logic                    stop_idx;
    logic [p_DATA_WIDTH-1:0] shreg;
    logic                    ferr;
    logic                    vote, at_vote, at_end, ferr_nx;
`ifdef UART_RX_PARITY_EN
    logic                    perr;
`else
    localparam logic         perr = ODD & 1'b0;
`endif

    // hist holds rx_s from the two previous cycles, so at VOTE_AT it covers mid-1 and mid
    assign vote    = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
    assign at_vote = (cnt == VOTE_AT);
    assign at_end  = (cnt == BIT_END);
    assign ferr_nx = ferr | ~vote;

    // two-flop synchroniser and sample history for the majority vote
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            hist <= 2'b11;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
            hist <= {hist[0], rx_s};
        end
    end

    // frame FSM with registered result pulses; the stop decision does not wait for bit end
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            stop_idx       <= 1'b0;
            shreg          <= '0;
            ferr           <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr           <= 1'b0;
`endif
            bus.data       <= '0;
            bus.valid      <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.valid      <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
            cnt            <= at_end ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state    <= START;
                        bus.busy <= 1'b1;
                    end
                end
                START: begin
                    if (at_vote && vote) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (at_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (at_vote) shreg <= {vote, shreg[p_DATA_WIDTH-1:1]};
                    if (at_end) begin
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                            ferr     <= 1'b0;
                            stop_idx <= 1'b0;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (at_vote) perr <= ((^shreg) ^ vote) != ODD;
                    if (at_end) begin
                        state    <= STOP;
                        ferr     <= 1'b0;
                        stop_idx <= 1'b0;
                    end
                end
`endif
                STOP: begin
                    if (at_vote) begin
                        ferr <= ferr_nx;
                        if (stop_idx == LAST_STOP) begin
                            bus.valid      <= !ferr_nx && !perr;
                            bus.frame_err  <= ferr_nx;
                            bus.parity_err <= perr;
                            bus.busy       <= 1'b0;
                            if (!ferr_nx && !perr) bus.data <= shreg;
                            state <= (ferr_nx && !rx_s) ? BRK : IDLE;
                        end
                    end else if (at_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                BRK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: scoreboard bench for uart_rx_frame (parity cases with UART_RX_PARITY_EN)
module tb_uart_rx_frame;
    localparam int DW  = 8;
    localparam int CPB = 16;
    localparam int MID = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR  = 1;
    localparam int STOP = 2;
`else
    localparam int PAR  = 0;
    localparam int STOP = 1;
`endif
    localparam logic ODD = 1'b0;
    localparam int LAT = 2 + (1 + DW + PAR + STOP - 1) * CPB + MID + 2;

    typedef struct packed {
        logic          v;
        logic          fe;
        logic          pe;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   fs = 0;
    int   pulse_cyc = -1;
    int   rise_cyc = -1;
    int   fall_cyc = -1;
    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame_if #(.p_DATA_WIDTH(DW)) bus ();

    uart_rx_frame #(
        .p_DATA_WIDTH(DW),
        .p_CLKS_PER_BIT(CPB),
        .p_STOP_BITS(STOP),
        .p_PARITY_ODD(0)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic v, input logic fe, input logic pe, input logic [DW-1:0] d);
        q.push_back('{v: v, fe: fe, pe: pe, d: d});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input logic glitch);
        for (int c = 0; c < CPB; c++) begin
            bus.rx = (glitch && c == MID) ? ~b : b;
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic pflip, input logic [1:0] stop, input int g);
        t0 = cyc + 1;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i], i == g);
        if (PAR != 0) drive_bit((^d) ^ ODD ^ pflip, 1'b0);
        for (int s = 0; s < STOP; s++) drive_bit(stop[s], 1'b0);
    endtask

    // monitor: every result pulse is matched against the head of the expectation queue
    initial begin
        logic pb;
        exp_t e;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.busy && !pb) rise_cyc = cyc;
            if (!bus.busy && pb) fall_cyc = cyc;
            pb = bus.busy;
            if (bus.valid || bus.frame_err || bus.parity_err) begin
                pulse_cyc = cyc;
                if (q.size() == 0) begin
                    check("unexpected_pulse", {29'd0, bus.valid, bus.frame_err, bus.parity_err}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("pulse_flags", {29'd0, bus.valid, bus.frame_err, bus.parity_err},
                          {29'd0, e.v, e.fe, e.pe});
                    check("pulse_data", 32'(bus.data), 32'(e.d));
                end
            end
        end
    end

    initial begin
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        tick(3);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_frame_err", 32'(bus.frame_err), 0);
        check("rst_parity_err", 32'(bus.parity_err), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_data", 32'(bus.data), 0);
        rst_n = 1'b1;
        tick(20);
        check("idle_busy", 32'(bus.busy), 0);

        push(1'b1, 1'b0, 1'b0, 8'hA5);
        send(8'hA5, 1'b0, 2'b11, -1);
        tick(4);
        check("latency", 32'(pulse_cyc - t0), 32'(LAT));
        check("busy_rise", 32'(rise_cyc - t0), 2);
        check("busy_fall", 32'(fall_cyc), 32'(pulse_cyc));
        check("busy_after_frame", 32'(bus.busy), 0);

        fs = cyc + 1;
        bus.rx = 1'b0;
        tick(4);
        bus.rx = 1'b1;
        tick(2 * CPB);
        check("false_start_rise", 32'(rise_cyc - fs), 2);
        check("false_start_len", 32'(fall_cyc - rise_cyc), 32'(MID + 2));
        check("false_start_busy", 32'(bus.busy), 0);

        push(1'b1, 1'b0, 1'b0, 8'h3C);
        send(8'h3C, 1'b0, 2'b11, 2);
        tick(4);

        push(1'b0, 1'b1, 1'b0, 8'h3C);
        send(8'h5A, 1'b0, 2'b00, -1);
        bus.rx = 1'b0;
        tick(40 * CPB);
        bus.rx = 1'b1;
        tick(2 * CPB);
        check("break_busy", 32'(bus.busy), 0);
        push(1'b1, 1'b0, 1'b0, 8'h81);
        send(8'h81, 1'b0, 2'b11, -1);
        tick(4);

        push(1'b1, 1'b0, 1'b0, 8'h00);
        push(1'b1, 1'b0, 1'b0, 8'hFF);
        send(8'h00, 1'b0, 2'b11, -1);
        send(8'hFF, 1'b0, 2'b11, -1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        check("midframe_busy", 32'(bus.busy), 1);
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        tick(1);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_valid", 32'(bus.valid), 0);
        tick(1);
        rst_n = 1'b1;
        tick(3 * CPB);
        check("post_abort_busy", 32'(bus.busy), 0);

`ifdef UART_RX_PARITY_EN
        push(1'b1, 1'b0, 1'b0, 8'h03);
        send(8'h03, 1'b0, 2'b11, -1);
        push(1'b0, 1'b0, 1'b1, 8'h03);
        send(8'h03, 1'b1, 2'b11, -1);
        push(1'b0, 1'b1, 1'b1, 8'h03);
        send(8'h03, 1'b1, 2'b01, -1);
        bus.rx = 1'b1;
        tick(2 * CPB);
`endif

        tick(4);
        check("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
